// File: rtl/pipe_ctrl.sv
// Five-stage pipeline control: allowin chain, flush, redirect FSM and fetch-discard tracking.
// Latency: allowin/flush/discard combinational, redirect one edge after the event; redirect held until redirect_ack_i.
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid_i,
  input  logic        id_valid_i,
  input  logic        exe_valid_i,
  input  logic        mem_valid_i,
  input  logic        wb_valid_i,
  input  logic        if_ready_go_i,
  input  logic        id_ready_go_i,
  input  logic        exe_ready_go_i,
  input  logic        mem_ready_go_i,
  input  logic        wb_ready_go_i,
  output logic        if_allowin_o,
  output logic        id_allowin_o,
  output logic        exe_allowin_o,
  output logic        mem_allowin_o,
  output logic        wb_allowin_o,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  input  logic        excp_i,
  input  logic [31:0] excp_entry_i,
  input  logic        ertn_i,
  input  logic [31:0] era_i,
  output logic        if_flush_o,
  output logic        id_flush_o,
  output logic        exe_flush_o,
  output logic        mem_flush_o,
  output logic        wb_flush_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  input  logic        redirect_ack_i,
  input  logic        inst_addr_ok_i,
  input  logic        inst_data_ok_i,
  output logic        inst_discard_o
);

  typedef enum logic [1:0] {RUN = 2'd0, REDIR = 2'd1, DRAIN = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  outst_q, outst_d;
  logic [1:0]  disc_q, disc_d;
  logic        br, ex, er, evt, flush_all;
  logic [31:0] evt_pc;

  assign wb_allowin_o  = !wb_valid_i  | wb_ready_go_i;
  assign mem_allowin_o = !mem_valid_i | (mem_ready_go_i & wb_allowin_o);
  assign exe_allowin_o = !exe_valid_i | (exe_ready_go_i & mem_allowin_o);
  assign id_allowin_o  = !id_valid_i  | (id_ready_go_i & exe_allowin_o);
  assign if_allowin_o  = !if_valid_i  | (if_ready_go_i & id_allowin_o);

  assign br  = exe_valid_i & br_taken_i;
  assign ex  = wb_valid_i & excp_i;
  assign er  = wb_valid_i & ertn_i & !excp_i;
  assign evt = ex | er | br;
  assign evt_pc = ex ? excp_entry_i : (er ? era_i : br_target_i);

  assign flush_all   = ex | er;
  assign if_flush_o  = flush_all | br;
  assign id_flush_o  = flush_all | br;
  assign exe_flush_o = flush_all;
  assign mem_flush_o = flush_all;
  assign wb_flush_o  = flush_all;

  // A word returning in the event cycle belongs to the squashed path if anything was in flight.
  assign inst_discard_o = inst_data_ok_i & ((disc_q != 2'd0) | (evt & (outst_q != 2'd0)));

  assign redirect_valid_o = (state_q == REDIR);
  assign redirect_pc_o    = redirect_valid_o ? pc_q : 32'd0;

  always_comb begin
    outst_d = outst_q;
    if (inst_addr_ok_i && !inst_data_ok_i && outst_q != 2'd3)
      outst_d = outst_q + 2'd1;
    else if (!inst_addr_ok_i && inst_data_ok_i && outst_q != 2'd0)
      outst_d = outst_q - 2'd1;
  end

  // On an event every fetch still in flight after this edge is wrong-path; a word
  // returning now is already consumed (and discarded) so it is not counted again.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    disc_d  = disc_q;
    if (evt) begin
      state_d = REDIR;
      pc_d    = evt_pc;
      disc_d  = outst_d;
    end else begin
      if (inst_discard_o)
        disc_d = disc_q - 2'd1;
      case (state_q)
        REDIR:   if (redirect_ack_i) state_d = (disc_d != 2'd0) ? DRAIN : RUN;
        DRAIN:   if (disc_d == 2'd0) state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= 32'd0;
      outst_q <= 2'd0;
      disc_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      outst_q <= outst_d;
      disc_q  <= disc_d;
    end
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; rst_n  in  1  asynchronous active-low reset.
REQ-002 SHALL have ports: {if,id,exe,mem,wb}_valid_i  in  1 each  stage-register valid bits.
REQ-003 SHALL have ports: {if,id,exe,mem,wb}_ready_go_i  in  1 each  stage has finished its work this cycle.
REQ-004 SHALL have ports: {id,exe,mem,wb}_allowin_o  out  1 each  next-stage acceptance to upstream register; if_allowin_o  out  1.
REQ-005 SHALL have ports: br_taken_i  in  1  EXE branch taken; br_target_i  in  32  branch target.
REQ-006 SHALL have ports: excp_i  in  1  WB exception; excp_entry_i  in  32  handler entry; ertn_i  in  1  WB ertn; era_i  in  32  return address.
REQ-007 SHALL have ports: {if,id,exe,mem,wb}_flush_o  out  1 each  flush to stage-register valid clear.
REQ-008 SHALL have ports: redirect_valid_o  out  1; redirect_pc_o  out  32; redirect_ack_i  in  1  fetch took the redirect.
REQ-009 SHALL have ports: inst_addr_ok_i  in  1  fetch request accepted; inst_data_ok_i  in  1  fetch data returned; inst_discard_o  out  1  drop this returned word.

Function
REQ-010 allowin SHALL be combinational: wb_allowin_o = !wb_valid_i | wb_ready_go_i; X_allowin_o = !X_valid_i | (X_ready_go_i & next_allowin) for mem, exe, id, if.
REQ-011 Events SHALL be qualified: br = exe_valid_i & br_taken_i; ex = wb_valid_i & excp_i; er = wb_valid_i & ertn_i & !excp_i.
REQ-012 Priority SHALL be ex > er > br, all seen in same cycle.
REQ-013 ex or er SHALL assert all five flush_o combinationally in that cycle; br SHALL assert if_flush_o and id_flush_o only.
REQ-014 FSM states SHALL be RUN, REDIR, DRAIN; encoding free.
REQ-015 Any event in RUN, DRAIN or REDIR SHALL, next edge, load redirect_pc (excp_entry_i / era_i / br_target_i by priority) and enter REDIR; later event overwrites pending pc.
REQ-016 redirect_valid_o SHALL be high exactly in REDIR; redirect_pc_o registered value, 0 outside REDIR.
REQ-017 REDIR with redirect_ack_i and no new event: next state DRAIN if discard count nonzero after update, else RUN.
REQ-018 DRAIN SHALL return to RUN the edge discard count reaches 0; no new event.
REQ-019 Outstanding counter (2 bit, 0..3) SHALL +1 on inst_addr_ok_i, -1 on inst_data_ok_i, unchanged if both.
REQ-020 On any event edge, discard count SHALL load outstanding-after-update minus any data_ok consumed as discard that cycle; counts never underflow.
REQ-021 inst_discard_o = inst_data_ok_i & (discard count != 0 | event this cycle with outstanding != 0); each discard decrements discard count.
REQ-022 Outstanding count at 3 with inst_addr_ok_i and no inst_data_ok_i SHALL saturate at 3 (protocol error, fetch guarantees ≤2).
REQ-023 Stall from ready_go_i low SHALL not change FSM or counters.
REQ-024 Flush outputs SHALL not depend on FSM state.

Reset
REQ-025 rst_n low SHALL asynchronously force state RUN, redirect_pc 0, outstanding 0, discard 0; redirect_valid_o 0, inst_discard_o 0.
REQ-026 Reset mid-REDIR or mid-DRAIN SHALL abandon the redirect with no pulse after release.
REQ-027 Combinational allowin/flush SHALL follow inputs during reset; stage registers clear themselves.

Verification
REQ-028 All valid=1, wb_ready_go=0, others ready -> all allowin 0 except stages with valid 0.
REQ-029 br at EXE, target 0x1c000040 -> if/id flush 1 same cycle, exe/mem/wb flush 0; next cycle redirect_valid_o 1, pc 0x1c000040; ack -> RUN.
REQ-030 br and excp same cycle, entry 0x1c008000 -> all flush 1; redirect_pc 0x1c008000.
REQ-031 2 outstanding fetches, br, ack next cycle -> DRAIN; two data_ok -> inst_discard_o 1 both; RUN after second.
REQ-032 ertn (era 0x1c000100) while REDIR with branch pending -> pc overwritten to 0x1c000100, stays REDIR.
REQ-033 rst_n low in DRAIN with discard 1 -> immediately RUN, counts 0; later data_ok not discarded.
